// File: rtl/path_meas_pkg.sv
// Shared types and default sizing for the path delay measurement controller.
package path_meas_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TRIALS_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/path_sync.sv
// Two-flop synchronizer that brings the asynchronous delay-chain output into the clk domain.
module path_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/path_measure_ctrl.sv
// Launches edges into a delay chain and times their return, accumulating sum/max over a run.
// Define PATH_MEAS_MIN_EN to add the delay_min output.
module path_measure_ctrl
    import path_meas_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TRIALS_W = DEF_TRIALS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [TRIALS_W-1:0]       num_trials,
    input  logic [CNT_W-1:0]          timeout,
    output logic                      path_launch,
    input  logic                      path_capture,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W+TRIALS_W-1:0] delay_sum,
    output logic [CNT_W-1:0]          delay_max,
    output logic                      timeout_err
`ifdef PATH_MEAS_MIN_EN
    ,
    output logic [CNT_W-1:0]          delay_min
`endif
);

    state_t                      r_state;
    state_t                      w_next;
    logic                        w_cap_s;
    logic                        r_launch;
    logic [CNT_W-1:0]            r_cnt;
    logic [TRIALS_W-1:0]         r_trials;
    logic [TRIALS_W-1:0]         r_num_trials;
    logic [CNT_W-1:0]            r_timeout;
    logic [CNT_W+TRIALS_W-1:0]   r_sum;
    logic [CNT_W-1:0]            r_max;
    logic                        r_timeout_err;
    logic                        w_match;
    logic                        w_expire;
    logic                        w_last;
    logic [TRIALS_W-1:0]         w_trials_inc;

    path_sync u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (path_capture),
        .o_q     (w_cap_s)
    );

    // A trial ends when the synchronized return matches the level just launched.
    assign w_match      = (r_state == WAIT) && (w_cap_s == r_launch);
    assign w_expire     = (r_state == WAIT) && !w_match && (r_cnt == r_timeout);
    assign w_trials_inc = r_trials + TRIALS_W'(1);
    assign w_last       = (w_trials_inc == r_num_trials);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LAUNCH;
            LAUNCH:  w_next = (r_num_trials == '0) ? DONE : WAIT;
            WAIT: begin
                if (w_match) begin
                    w_next = w_last ? DONE : LAUNCH;
                end else if (w_expire) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_launch      <= 1'b0;
            r_cnt         <= '0;
            r_trials      <= '0;
            r_num_trials  <= '0;
            r_timeout     <= '0;
            r_sum         <= '0;
            r_max         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num_trials  <= num_trials;
                        r_timeout     <= timeout;
                        r_sum         <= '0;
                        r_max         <= '0;
                        r_timeout_err <= 1'b0;
                        r_trials      <= '0;
                    end
                end
                LAUNCH: begin
                    if (r_num_trials != '0) begin
                        r_launch <= ~r_launch;
                        r_cnt    <= '0;
                    end
                end
                WAIT: begin
                    if (w_match) begin
                        r_sum    <= r_sum + {{TRIALS_W{1'b0}}, r_cnt};
                        r_trials <= w_trials_inc;
                        if (r_cnt > r_max) r_max <= r_cnt;
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PATH_MEAS_MIN_EN
    logic [CNT_W-1:0] r_min;

    // Starts at all-ones so the first completed trial always replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_min <= '1;
        end else if (w_match && (r_cnt < r_min)) begin
            r_min <= r_cnt;
        end
    end

    assign delay_min = r_min;
`endif

    assign path_launch = r_launch;
    assign busy        = (r_state == LAUNCH) || (r_state == WAIT);
    assign done        = (r_state == DONE);
    assign delay_sum   = r_sum;
    assign delay_max   = r_max;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/path_measure_ctrl.md
PATH_MEASURE_CTRL -- requirements
Module: path_measure_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the per-trial cycle counter and of timeout.
REQ-002 SHALL have parameter TRIALS_W, default 8, giving the width of num_trials and of the trial counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a measurement run.
REQ-006 SHALL have port num_trials, input, TRIALS_W bits: number of launch/capture trials, sampled on accepted start.
REQ-007 SHALL have port timeout, input, CNT_W bits: maximum wait cycles per trial, sampled on accepted start.
REQ-008 SHALL have port path_launch, output, 1 bit: drives the delay-chain input.
REQ-009 SHALL have port path_capture, input, 1 bit: the delay-chain output, asynchronous to clk.
REQ-010 SHALL have port busy, output, 1 bit: high from accepted start until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-012 SHALL have port delay_sum, output, CNT_W+TRIALS_W bits: sum of the per-trial counts for the last run.
REQ-013 SHALL have port delay_max, output, CNT_W bits: largest per-trial count for the last run.
REQ-014 SHALL have port timeout_err, output, 1 bit: the last run aborted on timeout.

Function
REQ-015 SHALL pass path_capture through a 2-flop synchronizer before any use; the output of this synchronizer is cap_s.
REQ-016 SHALL implement FSM states IDLE, LAUNCH, WAIT, DONE.
REQ-017 SHALL, in IDLE with start=1, latch num_trials and timeout, clear delay_sum, delay_max, timeout_err and the trial counter, and go to LAUNCH.
REQ-018 SHALL, if the latched num_trials=0, go from LAUNCH directly to DONE without toggling path_launch, leaving delay_sum=0 and delay_max=0.
REQ-019 SHALL, in LAUNCH, toggle path_launch, set the cycle counter to 0, and go to WAIT; the toggle cycle is cycle 0.
REQ-020 SHALL, in WAIT, increment the cycle counter each cycle; on the first cycle where cap_s equals path_launch, the counter value is that trial's count.
REQ-021 SHALL, on a match, add the count to delay_sum, update delay_max if the count is larger, and increment the trial counter.
REQ-022 SHALL, on a match, go to DONE if the trial counter reaches num_trials, else go to LAUNCH.
REQ-023 SHALL make consecutive trials alternate rising and falling launch edges.
REQ-024 SHALL measure a zero-delay path (path_capture tied to path_launch) as count 2, which is the synchronizer latency.
REQ-025 SHALL, when the counter equals the latched timeout without a match, set timeout_err=1, leave path_launch unchanged, and go to DONE; completed trials remain accumulated.
REQ-026 SHALL, in DONE, assert done for exactly one cycle and return to IDLE; results hold until the next accepted start.
REQ-027 SHALL ignore start while busy=1, and SHALL ignore start during the DONE cycle.
REQ-028 SHALL size delay_sum so that it cannot overflow, given CNT_W+TRIALS_W bits.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force IDLE, with path_launch=0, busy=0, done=0, delay_sum=0, delay_max=0, timeout_err=0, all counters=0, and the synchronizer flops=0.
REQ-030 SHALL, on reset mid-run, discard all partial results; there is no resume.

Configuration
REQ-031 SHALL, when macro PATH_MEAS_MIN_EN is defined, add output delay_min (CNT_W bits) holding the smallest per-trial count; it is reset to all-ones on an accepted start and to 0 on rst_n.
REQ-032 SHALL, without PATH_MEAS_MIN_EN, omit the delay_min port and its logic entirely.

Structure
REQ-033 SHALL place the FSM state enum and the default CNT_W/TRIALS_W constants in shared package path_meas_pkg.
REQ-034 SHALL implement the synchronizer as sub-module path_sync, a 2-flop design with an asynchronous active-low reset.

Verification
REQ-035 SHALL cover: path_capture = path_launch delayed 5 clk, num_trials=4, timeout=100 -> delay_sum=28, delay_max=7, timeout_err=0, done pulses once.
REQ-036 SHALL cover: path_capture tied to 0, num_trials=3, timeout=20 -> trial 1 (rising) times out at count 20, timeout_err=1, delay_sum=0, path_launch=1.
REQ-037 SHALL cover: num_trials=0 -> done 2 cycles after start, path_launch never toggles, all results 0.
REQ-038 SHALL cover: start pulsed again while busy -> no effect, and results match a single run.
REQ-039 SHALL cover: rst_n asserted during WAIT of trial 2 -> all outputs 0 immediately, then a fresh run completes normally.
REQ-040 SHALL cover, with PATH_MEAS_MIN_EN: alternating delays 3/6 clk, num_trials=4 -> delay_min=5, delay_max=8, delay_sum=26.
